// File: rtl/seg_scan_pwm.sv
// -----------------------------------------------------------------------------
// seg_scan_pwm
// Time-multiplexed N-digit 7-segment scanner with PWM brightness, per-digit
// blanking and blinking. Sits between the per-digit segment encoders and the
// board anode/segment pins and runs on the divided scan tick.
//
// All display inputs (digit patterns, brightness, blank and blink masks) are
// captured into snapshot registers at reset and at every frame wrap. A frame
// therefore always shows one coherent set of inputs and never tears.
//
// Ports
//   p625        in   1                 scan tick clock (only clock)
//   rst         in   1                 synchronous, active-high reset
//   scan_en     in   1                 1 = scan runs, 0 = counters hold, display dark
//   digits_in   in   DIGITS*SEG_W      digit k at [k*SEG_W +: SEG_W]
//   bright      in   BRIGHT_W          brightness code, 0 = dimmest
//   blank_mask  in   DIGITS            1 = digit k never lit
//   blink_mask  in   DIGITS            1 = digit k dark while blink phase is 1
//   num         out  SEG_W             segment pattern of active digit
//   en          out  DIGITS            active-low anode enables (at most one low)
//   dig_idx     out  clog2(DIGITS)     index of the digit being driven
//   frame_start out  1                 pulse on first output cycle of digit 0
// -----------------------------------------------------------------------------
module seg_scan_pwm #(
   parameter int DIGITS     = 4,
   parameter int SEG_W      = 7,
   parameter int SLOT_BITS  = 4,
   parameter int BRIGHT_W   = 2,
   parameter int BLINK_BITS = 6
) (
   input  logic                       p625,
   input  logic                       rst,
   input  logic                       scan_en,
   input  logic [DIGITS*SEG_W-1:0]    digits_in,
   input  logic [BRIGHT_W-1:0]        bright,
   input  logic [DIGITS-1:0]          blank_mask,
   input  logic [DIGITS-1:0]          blink_mask,
   output logic [SEG_W-1:0]           num,
   output logic [DIGITS-1:0]          en,
   output logic [$clog2(DIGITS)-1:0]  dig_idx,
   output logic                       frame_start
);

   localparam int DIG_W    = $clog2(DIGITS);
   localparam int ON_SHIFT = SLOT_BITS - BRIGHT_W;

   localparam logic [SLOT_BITS-1:0]  TICK_MAX  = {SLOT_BITS{1'b1}};
   localparam logic [SLOT_BITS-1:0]  TICK_ZERO = {SLOT_BITS{1'b0}};
   localparam logic [SLOT_BITS-1:0]  TICK_ONE  = SLOT_BITS'(1);
   localparam logic [DIG_W-1:0]      DIG_ZERO  = {DIG_W{1'b0}};
   localparam logic [DIG_W-1:0]      DIG_ONE   = DIG_W'(1);
   localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(DIGITS - 1);
   localparam logic [BLINK_BITS-1:0] BCNT_ONE  = BLINK_BITS'(1);
   localparam logic [SLOT_BITS:0]    ON_ONE    = (SLOT_BITS + 1)'(1);

   // Scan counters
   logic [SLOT_BITS-1:0]      tick_r;
   logic [DIG_W-1:0]          dig_r;
   logic [BLINK_BITS-1:0]     bcnt_r;

   // Frame snapshots of the display inputs
   logic [DIGITS*SEG_W-1:0]   snap_dig_r;
   logic [BRIGHT_W-1:0]       snap_bright_r;
   logic [DIGITS-1:0]         snap_blank_r;
   logic [DIGITS-1:0]         snap_blink_r;

   // Combinational next-state and next-output values
   logic                      tick_wrap_s;
   logic                      dig_last_s;
   logic                      frame_wrap_s;
   logic [SLOT_BITS-1:0]      tick_nxt_s;
   logic [DIG_W-1:0]          dig_nxt_s;
   logic [BLINK_BITS-1:0]     bcnt_nxt_s;
   logic [SEG_W-1:0]          seg_sel_s;
   logic                      blank_sel_s;
   logic                      blink_sel_s;
   logic [SLOT_BITS:0]        bright_ext_s;
   logic [SLOT_BITS:0]        on_ticks_s;
   logic                      lit_s;
   logic [DIGITS-1:0]         en_nxt_s;
   logic                      frame_first_s;

   // Counter next-state: tick rolls over into the digit index, digit rolls into the frame counter
   always_comb begin
      tick_wrap_s  = (tick_r == TICK_MAX);
      dig_last_s   = (dig_r == DIG_LAST);
      frame_wrap_s = tick_wrap_s && dig_last_s;
      tick_nxt_s   = tick_r + TICK_ONE;
      if (tick_wrap_s) begin
         // explicit wrap keeps dig below DIGITS even when DIGITS is not a power of two
         if (dig_last_s) begin
            dig_nxt_s = DIG_ZERO;
         end else begin
            dig_nxt_s = dig_r + DIG_ONE;
         end
      end else begin
         dig_nxt_s = dig_r;
      end
      if (frame_wrap_s) begin
         bcnt_nxt_s = bcnt_r + BCNT_ONE;
      end else begin
         bcnt_nxt_s = bcnt_r;
      end
   end

   // Select the snapshot fields of the digit addressed by dig_r
   always_comb begin
      seg_sel_s   = {SEG_W{1'b0}};
      blank_sel_s = 1'b0;
      blink_sel_s = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         seg_sel_s   = (dig_r == DIG_W'(k)) ? snap_dig_r[k*SEG_W +: SEG_W] : seg_sel_s;
         blank_sel_s = (dig_r == DIG_W'(k)) ? snap_blank_r[k]            : blank_sel_s;
         blink_sel_s = (dig_r == DIG_W'(k)) ? snap_blink_r[k]            : blink_sel_s;
      end
   end

   // PWM window and anode decode for the current slot
   always_comb begin
      // on_ticks never exceeds 2^SLOT_BITS-1, so the final tick of a slot is always dark
      bright_ext_s  = {{(SLOT_BITS + 1 - BRIGHT_W){1'b0}}, snap_bright_r};
      on_ticks_s    = ((bright_ext_s + ON_ONE) << ON_SHIFT) - ON_ONE;
      lit_s         = ({1'b0, tick_r} < on_ticks_s)
                      && !blank_sel_s
                      && !(blink_sel_s && bcnt_r[BLINK_BITS-1]);
      frame_first_s = (tick_r == TICK_ZERO) && (dig_r == DIG_ZERO);
      en_nxt_s      = {DIGITS{1'b1}};
      for (int k = 0; k < DIGITS; k++) begin
         en_nxt_s[k] = ((dig_r == DIG_W'(k)) && lit_s) ? 1'b0 : 1'b1;
      end
   end

   // Scan counters: hold while scanning is disabled
   always_ff @(posedge p625) begin
      if (rst) begin
         tick_r <= TICK_ZERO;
         dig_r  <= DIG_ZERO;
         bcnt_r <= {BLINK_BITS{1'b0}};
      end else if (scan_en) begin
         tick_r <= tick_nxt_s;
         dig_r  <= dig_nxt_s;
         bcnt_r <= bcnt_nxt_s;
      end else begin
         tick_r <= tick_r;
         dig_r  <= dig_r;
         bcnt_r <= bcnt_r;
      end
   end

   // Input snapshots: reload only at reset or on an enabled frame wrap
   always_ff @(posedge p625) begin
      if (rst || (scan_en && frame_wrap_s)) begin
         snap_dig_r    <= digits_in;
         snap_bright_r <= bright;
         snap_blank_r  <= blank_mask;
         snap_blink_r  <= blink_mask;
      end else begin
         snap_dig_r    <= snap_dig_r;
         snap_bright_r <= snap_bright_r;
         snap_blank_r  <= snap_blank_r;
         snap_blink_r  <= snap_blink_r;
      end
   end

   // Registered pin outputs, one cycle behind the counter state
   always_ff @(posedge p625) begin
      if (rst) begin
         num         <= {SEG_W{1'b0}};
         en          <= {DIGITS{1'b1}};
         dig_idx     <= DIG_ZERO;
         frame_start <= 1'b0;
      end else if (scan_en) begin
         num         <= seg_sel_s;
         en          <= en_nxt_s;
         dig_idx     <= dig_r;
         frame_start <= frame_first_s;
      end else begin
         // paused: go dark but keep the last pattern and index on the pins
         num         <= num;
         en          <= {DIGITS{1'b1}};
         dig_idx     <= dig_idx;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_scan_pwm.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_pwm
// Self-checking bench for seg_scan_pwm. Instance "dut" is a 4-digit scanner
// with a 2-bit blink counter, checked every cycle against a frame-position
// model. Instance "dut3" is a 3-digit scanner checked against closed-form
// expectations for the non-power-of-two case and a mid-slot reset.
// -----------------------------------------------------------------------------
module tb_seg_scan_pwm;

   logic p625 = 1'b0;
   always #5 p625 = ~p625;

   // 4-digit instance
   logic        rst, scan_en;
   logic [27:0] digits_in;
   logic [1:0]  bright;
   logic [3:0]  blank_mask, blink_mask;
   logic [6:0]  num;
   logic [3:0]  en;
   logic [1:0]  dig_idx;
   logic        frame_start;

   // 3-digit instance
   logic        rst_b, scan_en_b;
   logic [20:0] digits_b;
   logic [1:0]  bright_b;
   logic [2:0]  blank_b, blink_b;
   logic [6:0]  num_b;
   logic [2:0]  en_b;
   logic [1:0]  idx_b;
   logic        fs_b;

   seg_scan_pwm #(.DIGITS(4), .SEG_W(7), .SLOT_BITS(4), .BRIGHT_W(2), .BLINK_BITS(2)) dut (
      .p625(p625), .rst(rst), .scan_en(scan_en), .digits_in(digits_in), .bright(bright),
      .blank_mask(blank_mask), .blink_mask(blink_mask), .num(num), .en(en),
      .dig_idx(dig_idx), .frame_start(frame_start));

   seg_scan_pwm #(.DIGITS(3), .SEG_W(7), .SLOT_BITS(4), .BRIGHT_W(2), .BLINK_BITS(2)) dut3 (
      .p625(p625), .rst(rst_b), .scan_en(scan_en_b), .digits_in(digits_b), .bright(bright_b),
      .blank_mask(blank_b), .blink_mask(blink_b), .num(num_b), .en(en_b),
      .dig_idx(idx_b), .frame_start(fs_b));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: position inside a 64-clock frame, frame count, frame snapshots
   int         m_pos, m_frame, m_bright;
   logic [6:0] m_dig [4];
   logic [3:0] m_blank, m_blink;
   logic [6:0] e_num;
   logic [3:0] e_en;
   logic [1:0] e_idx;
   logic       e_fs;

   task automatic load_model();
      for (int k = 0; k < 4; k++) m_dig[k] = digits_in[k*7 +: 7];
      m_bright = int'(bright);
      m_blank  = blank_mask;
      m_blink  = blink_mask;
   endtask

   // One clock: advance the model with the inputs present at the edge, then settle
   task automatic step();
      int slot, t;
      @(posedge p625);
      if (rst) begin
         m_pos = 0; m_frame = 0; load_model();
         e_num = 7'h00; e_en = 4'hF; e_idx = 2'd0; e_fs = 1'b0;
      end else if (scan_en) begin
         slot  = m_pos / 16;
         t     = m_pos % 16;
         e_idx = slot[1:0];
         e_num = m_dig[slot];
         e_fs  = (m_pos == 0);
         e_en  = 4'hF;
         if (t < (m_bright + 1) * 4 - 1 && !m_blank[slot] && !(m_blink[slot] && (m_frame % 4) >= 2))
            e_en[slot] = 1'b0;
         m_pos++;
         if (m_pos == 64) begin
            m_pos = 0; m_frame++; load_model();
         end
      end else begin
         e_en = 4'hF; e_fs = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; scan_en = 1'b1; bright = 2'd3;
      digits_in = {7'h04, 7'h03, 7'h02, 7'h01};
      blank_mask = 4'b0000; blink_mask = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++;
         if ({num, en, dig_idx, frame_start} !== {7'h00, 4'hF, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: num=%h en=%b idx=%0d fs=%b expected 00 1111 0 0", num, en, dig_idx, frame_start);
         end
      end
   endtask

   task automatic test_basic_scan();
      int fs_cnt, fs_at [2];
      fs_cnt = 0;
      rst = 1'b0;
      for (int c = 0; c < 128; c++) begin
         step();
         n_chk++;
         if ({num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
            n_fail++;
            $display("FAIL basic_scan c=%0d: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                     c, num, en, dig_idx, frame_start, e_num, e_en, e_idx, e_fs);
         end
         if (frame_start) begin
            if (fs_cnt < 2) fs_at[fs_cnt] = c;
            fs_cnt++;
         end
      end
      n_chk++;
      if (fs_cnt != 2 || fs_at[0] != 0 || fs_at[1] != 64) begin
         n_fail++;
         $display("FAIL frame_period: %0d pulses at %0d,%0d expected 2 pulses at 0,64", fs_cnt, fs_at[0], fs_at[1]);
      end
   endtask

   task automatic test_brightness();
      int cnt [4];
      int guard;
      for (int b = 0; b < 3; b++) begin
         digits_in = 28'($urandom);
         for (int i = 0; i < int'($urandom_range(5, 40)); i++) step();
         while (m_pos < 2) step();
         bright = 2'(b);
         guard = 0;
         do begin
            step(); guard++;
            n_chk++;
            if ({num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
               n_fail++;
               $display("FAIL bright_change b=%0d: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                        b, num, en, dig_idx, frame_start, e_num, e_en, e_idx, e_fs);
            end
         end while (!frame_start && guard < 200);
         n_chk++;
         if (!frame_start) begin
            n_fail++;
            $display("FAIL bright_wait: frame_start=%b after %0d cycles, expected 1", frame_start, guard);
         end
         for (int k = 0; k < 4; k++) cnt[k] = 0;
         for (int c = 0; c < 64; c++) begin
            if (c != 0) begin
               step();
               n_chk++;
               if ({num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
                  n_fail++;
                  $display("FAIL bright_frame b=%0d: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                           b, num, en, dig_idx, frame_start, e_num, e_en, e_idx, e_fs);
               end
            end
            for (int k = 0; k < 4; k++) if (en[k] == 1'b0) cnt[k]++;
         end
         for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (cnt[k] != 3 + 4 * b) begin
               n_fail++;
               $display("FAIL bright_lit b=%0d digit %0d: lit %0d cycles expected %0d", b, k, cnt[k], 3 + 4 * b);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      logic [27:0] old_v, new_v;
      int guard;
      bright = 2'd3;
      guard = 0;
      while (dig_idx != 2'd2 && guard < 100) begin step(); guard++; end
      old_v = digits_in;
      new_v = old_v ^ (28'($urandom) | {4{7'h01}});
      digits_in = new_v;
      guard = 0;
      do begin
         step(); guard++;
         n_chk++;
         if ({num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
            n_fail++;
            $display("FAIL snapshot_scan: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                     num, en, dig_idx, frame_start, e_num, e_en, e_idx, e_fs);
         end
      end while (dig_idx != 2'd3 && guard < 100);
      n_chk++;
      if (dig_idx !== 2'd3 || num !== old_v[27:21]) begin
         n_fail++;
         $display("FAIL snapshot_old: idx=%0d num=%h expected idx=3 num=%h", dig_idx, num, old_v[27:21]);
      end
      guard = 0;
      while (!frame_start && guard < 100) begin step(); guard++; end
      n_chk++;
      if (frame_start !== 1'b1 || num !== new_v[6:0]) begin
         n_fail++;
         $display("FAIL snapshot_new: fs=%b num=%h expected fs=1 num=%h", frame_start, num, new_v[6:0]);
      end
      guard = 0;
      while (dig_idx != 2'd3 && guard < 100) begin step(); guard++; end
      n_chk++;
      if (dig_idx !== 2'd3 || num !== new_v[27:21]) begin
         n_fail++;
         $display("FAIL snapshot_new3: idx=%0d num=%h expected idx=3 num=%h", dig_idx, num, new_v[27:21]);
      end
   endtask

   task automatic test_masks();
      int lit [4];
      int frame_id, guard;
      bright = 2'd3; blank_mask = 4'b0100; blink_mask = 4'b0001;
      guard = 0;
      do begin step(); guard++; end while (!frame_start && guard < 200);
      for (int f = 0; f < 4; f++) begin
         frame_id = m_frame;
         for (int k = 0; k < 4; k++) lit[k] = 0;
         for (int c = 0; c < 64; c++) begin
            if (!(f == 0 && c == 0)) step();
            n_chk++;
            if ({num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
               n_fail++;
               $display("FAIL masks_scan: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                        num, en, dig_idx, frame_start, e_num, e_en, e_idx, e_fs);
            end
            for (int k = 0; k < 4; k++) if (en[k] == 1'b0) lit[k]++;
         end
         n_chk++;
         if (lit[0] != (((frame_id % 4) < 2) ? 15 : 0) || lit[1] != 15 || lit[2] != 0 || lit[3] != 15) begin
            n_fail++;
            $display("FAIL masks_lit bcnt=%0d: lit %0d/%0d/%0d/%0d expected %0d/15/0/15",
                     frame_id % 4, lit[0], lit[1], lit[2], lit[3], ((frame_id % 4) < 2) ? 15 : 0);
         end
      end
   endtask

   task automatic test_scan_enable();
      int guard, run, lit;
      blank_mask = 4'b0000; blink_mask = 4'b0000; bright = 2'd3;
      guard = 0;
      while (m_pos != 21 && guard < 200) begin step(); guard++; end
      scan_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_chk++;
         if (en !== 4'hF || dig_idx !== 2'd1 || frame_start !== 1'b0 || {num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
            n_fail++;
            $display("FAIL scan_pause i=%0d: en=%b idx=%0d fs=%b num=%h expected en=1111 idx=1 fs=0 num=%h", i, en, dig_idx, frame_start, num, e_num);
         end
      end
      scan_en = 1'b1;
      run = 0; lit = 0; guard = 0;
      do begin
         step(); guard++;
         if (dig_idx == 2'd1) begin
            run++;
            if (en == 4'b1101) lit++;
         end
      end while (dig_idx == 2'd1 && guard < 40);
      n_chk++;
      if (run != 11 || lit != 10) begin
         n_fail++;
         $display("FAIL scan_resume: digit1 ran %0d cycles lit %0d expected 11 cycles lit 10", run, lit);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) digits_in = 28'($urandom);
         if ($urandom_range(0, 19) == 0) bright = 2'($urandom);
         if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom);
         if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom);
         if ($urandom_range(0, 24) == 0) scan_en = ~scan_en;
         rst = ($urandom_range(0, 299) == 0);
         step();
         n_chk++;
         if ({num, en, dig_idx, frame_start} !== {e_num, e_en, e_idx, e_fs}) begin
            n_fail++;
            $display("FAIL random c=%0d: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                     c, num, en, dig_idx, frame_start, e_num, e_en, e_idx, e_fs);
         end
      end
      rst = 1'b0; scan_en = 1'b1;
   endtask

   task automatic test_three_digits();
      int slot;
      logic [2:0] x_en;
      digits_b = 21'($urandom); bright_b = 2'd3; blank_b = 3'b000; blink_b = 3'b000; scan_en_b = 1'b1;
      step();
      n_chk++;
      if ({num_b, en_b, idx_b, fs_b} !== {7'h00, 3'b111, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL d3_reset: num=%h en=%b idx=%0d fs=%b expected 00 111 0 0", num_b, en_b, idx_b, fs_b);
      end
      rst_b = 1'b0;
      for (int j = 0; j < 167; j++) begin
         step();
         slot = (j / 16) % 3;
         x_en = 3'b111;
         if (j % 16 < 15) x_en[slot] = 1'b0;
         n_chk++;
         if ({num_b, en_b, idx_b, fs_b} !== {digits_b[slot*7 +: 7], x_en, 2'(slot), 1'(j % 48 == 0)}) begin
            n_fail++;
            $display("FAIL d3_scan j=%0d: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                     j, num_b, en_b, idx_b, fs_b, digits_b[slot*7 +: 7], x_en, slot, j % 48 == 0);
         end
      end
      rst_b = 1'b1;
      step();
      n_chk++;
      if ({num_b, en_b, idx_b, fs_b} !== {7'h00, 3'b111, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL d3_midslot_reset: num=%h en=%b idx=%0d fs=%b expected 00 111 0 0", num_b, en_b, idx_b, fs_b);
      end
      rst_b = 1'b0;
      for (int j = 0; j < 48; j++) begin
         step();
         slot = j / 16;
         x_en = 3'b111;
         if (j % 16 < 15) x_en[slot] = 1'b0;
         n_chk++;
         if ({num_b, en_b, idx_b, fs_b} !== {digits_b[slot*7 +: 7], x_en, 2'(slot), 1'(j == 0)}) begin
            n_fail++;
            $display("FAIL d3_restart j=%0d: num=%h en=%b idx=%0d fs=%b expected num=%h en=%b idx=%0d fs=%b",
                     j, num_b, en_b, idx_b, fs_b, digits_b[slot*7 +: 7], x_en, slot, j == 0);
         end
      end
   endtask

   initial begin
      rst_b = 1'b1; scan_en_b = 1'b1; digits_b = 21'h0; bright_b = 2'd0; blank_b = 3'b000; blink_b = 3'b000;
      test_reset();
      test_basic_scan();
      test_brightness();
      test_snapshot();
      test_masks();
      test_scan_enable();
      test_random();
      test_three_digits();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
